matrix_load_sequencer: RTL and testbench
========================================

Name: matrix_load_sequencer

Overview:
- Write-side controller for the dual-clock row BRAM that holds a matrix for Ethernet transmission.
- Accepts a stream of (row, col, element) tuples on inter_refclk and assembles each row into a MAX_COLS*ELEM_W word.
- Issues exactly one BRAM write per row, then signals matrix completion so the read-side (eth_refclk) transmitter can start.

Parameters:
ELEM_W, 8, width of one matrix element in bits
MAX_COLS, 32, elements per row word; BRAM width = MAX_COLS*ELEM_W
MAX_ROWS, 32, BRAM depth / maximum rows per matrix
TIMEOUT_CYCLES, 1024, idle-cycle limit for the optional watchdog

Ports:
inter_refclk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  element tuple valid
in_ready  out  1  sequencer can accept a tuple this cycle
in_row  in  $clog2(MAX_ROWS)  row index of element
in_col  in  $clog2(MAX_COLS)  column index of element
in_elem  in  ELEM_W  element value
in_last  in  1  final element of the matrix
bram_addra  out  $clog2(MAX_ROWS)  BRAM write address
bram_dina  out  MAX_COLS*ELEM_W  BRAM write data
bram_wea  out  1  BRAM write enable
matrix_done  out  1  one-cycle pulse after the final row is written
rows_written  out  $clog2(MAX_ROWS)+1  rows committed for the current matrix
busy  out  1  high in every state except IDLE
err_order  out  1  sticky flag: a row index below the current row was received
timeout  out  1  one-cycle pulse on watchdog flush (optional feature)

Behaviour:
- Transfer occurs when in_valid && in_ready. in_ready=1 in IDLE and FILL; 0 in COMMIT, FLUSH and DONE.
- Packing: column c occupies bits [(MAX_COLS-1-c)*ELEM_W +: ELEM_W]; column 0 is in the MSBs. Unwritten columns read 0. A repeated column overwrites the earlier value.
- States:
  - IDLE: on transfer, clear buffer, place element, cur_row<=in_row, rows_written<=0, err_order<=0. Go to FLUSH if in_last, else FILL.
  - FILL, same row: place element. Go to FLUSH if in_last, else stay.
  - FILL, in_row>cur_row: capture tuple into pending register, pend_last<=in_last, go to COMMIT.
  - FILL, in_row<cur_row: drop element, set err_order. If in_last, go to FLUSH; else stay.
  - COMMIT (1 cycle): bram_wea=1, bram_addra=cur_row, bram_dina=buffer. rows_written++. Buffer <= zeros with pending element placed, cur_row<=pending row. Go to FLUSH if pend_last, else FILL.
  - FLUSH (1 cycle): write cur_row as in COMMIT, rows_written++, go to DONE.
  - DONE (1 cycle): matrix_done=1, go to IDLE.
- bram_addra/bram_dina are registered outputs and are valid in the same cycle as bram_wea. bram_wea is never high for more than one consecutive cycle per row.
- Latency: last tuple accepted in cycle N -> final write in N+1 -> matrix_done in N+2. A new-row, last tuple at N -> COMMIT N+1, FLUSH N+2, DONE N+3.
- Skipped row indices are not written; their BRAM contents are untouched.
- Reset, including mid-operation: state=IDLE, buffer and pending cleared, all outputs 0 except in_ready=1. No BRAM write is issued in the reset cycle.

Optional Feature:
- Macro: LOAD_TIMEOUT_EN.
- Defined: a counter runs in FILL, clears on every transfer, and reaches TIMEOUT_CYCLES after TIMEOUT_CYCLES consecutive idle cycles. On reaching it, go to FLUSH exactly as if in_last had been received, and pulse timeout for one cycle together with the FLUSH write.
- Undefined: no counter; timeout tied to 0; FILL waits indefinitely.

Test Plan:
- Row 2, cols 0..31, values 1..32, in_last on col 31 -> one write: addra=2, dina MSB byte=0x01, LSB byte=0x20; matrix_done 2 cycles after last; rows_written=1.
- Rows 0,1,2 with 4 elements each, in_last on row 2 -> writes to addresses 0,1,2 in order; in_ready low one cycle at each row change; rows_written=3.
- Row 5 then row 3 element 0xAA -> err_order=1, 0xAA absent from every write, err_order cleared on the next matrix's first transfer.
- Row 1 col 4=0x11, then row 4 col 0=0x22 with in_last -> COMMIT addr 1, FLUSH addr 4 (MSB byte 0x22), matrix_done 3 cycles after the last tuple.
- rst asserted during FILL after 3 elements -> no write, outputs 0, in_ready=1; next matrix starts with a cleared buffer.
- With LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=16, one element then idle -> FLUSH write plus timeout pulse after 16 idle cycles, then matrix_done.

Source files
------------

// File: rtl/matrix_load_sequencer.sv
// Write-side row assembler for the dual-clock matrix BRAM: packs (row, col, elem) tuples
// into one MAX_COLS*ELEM_W word per row. Optional idle watchdog enabled by LOAD_TIMEOUT_EN.
module matrix_load_sequencer #(
   parameter int ELEM_W         = 8,
   parameter int MAX_COLS       = 32,
   parameter int MAX_ROWS       = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          inter_refclk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [$clog2(MAX_ROWS)-1:0]   in_row,
   input  logic [$clog2(MAX_COLS)-1:0]   in_col,
   input  logic [ELEM_W-1:0]             in_elem,
   input  logic                          in_last,
   output logic [$clog2(MAX_ROWS)-1:0]   bram_addra,
   output logic [MAX_COLS*ELEM_W-1:0]    bram_dina,
   output logic                          bram_wea,
   output logic                          matrix_done,
   output logic [$clog2(MAX_ROWS):0]     rows_written,
   output logic                          busy,
   output logic                          err_order,
   output logic                          timeout
);

   localparam int ROW_W  = $clog2(MAX_ROWS);
   localparam int COL_W  = $clog2(MAX_COLS);
   localparam int DATA_W = MAX_COLS * ELEM_W;
   localparam int CNT_W  = ROW_W + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_COMMIT,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t               r_state;
   logic [DATA_W-1:0]    r_buf;
   logic [ROW_W-1:0]     r_curRow;
   logic [ROW_W-1:0]     r_pendRow;
   logic [COL_W-1:0]     r_pendCol;
   logic [ELEM_W-1:0]    r_pendElem;
   logic                 r_pendLast;
   logic                 r_inReady;
   logic                 r_wea;
   logic [ROW_W-1:0]     r_addra;
   logic [DATA_W-1:0]    r_dina;
   logic                 r_done;
   logic [CNT_W-1:0]     r_rowsWritten;
   logic                 r_busy;
   logic                 r_errOrder;

   logic                 w_xfer;
   logic [DATA_W-1:0]    w_freshPlaced;
   logic [DATA_W-1:0]    w_bufPlaced;
   logic [DATA_W-1:0]    w_pendPlaced;

`ifdef LOAD_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMR_W-1:0]     r_idleCnt;
   logic                 r_timeout;
`endif

   // Column 0 lands in the most significant element slot of the row word.
   function automatic logic [DATA_W-1:0] placeElem(input logic [DATA_W-1:0] base,
                                                   input logic [COL_W-1:0]  col,
                                                   input logic [ELEM_W-1:0] elem);
      logic [DATA_W-1:0] result;
      result = base;
      result[(MAX_COLS - 1 - int'(col)) * ELEM_W +: ELEM_W] = elem;
      return result;
   endfunction

   assign w_xfer = in_valid && r_inReady;

   always_comb begin
      w_freshPlaced = placeElem('0, in_col, in_elem);
      w_bufPlaced   = placeElem(r_buf, in_col, in_elem);
      w_pendPlaced  = placeElem('0, r_pendCol, r_pendElem);
   end

   always_ff @(posedge inter_refclk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_buf         <= '0;
         r_curRow      <= '0;
         r_pendRow     <= '0;
         r_pendCol     <= '0;
         r_pendElem    <= '0;
         r_pendLast    <= 1'b0;
         r_inReady     <= 1'b1;
         r_wea         <= 1'b0;
         r_addra       <= '0;
         r_dina        <= '0;
         r_done        <= 1'b0;
         r_rowsWritten <= '0;
         r_busy        <= 1'b0;
         r_errOrder    <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
         r_idleCnt     <= '0;
         r_timeout     <= 1'b0;
`endif
      end else begin
         r_wea  <= 1'b0;
         r_done <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
         r_timeout <= 1'b0;
         if (r_state != S_FILL)
            r_idleCnt <= '0;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_xfer) begin
                  r_buf         <= w_freshPlaced;
                  r_curRow      <= in_row;
                  r_errOrder    <= 1'b0;
                  r_busy        <= 1'b1;
                  if (in_last) begin
                     r_wea         <= 1'b1;
                     r_addra       <= in_row;
                     r_dina        <= w_freshPlaced;
                     r_rowsWritten <= CNT_W'(1);
                     r_inReady     <= 1'b0;
                     r_state       <= S_FLUSH;
                  end else begin
                     r_rowsWritten <= '0;
                     r_state       <= S_FILL;
                  end
               end
            end

            S_FILL: begin
`ifdef LOAD_TIMEOUT_EN
               r_idleCnt <= r_idleCnt + TMR_W'(1);
`endif
               if (w_xfer) begin
`ifdef LOAD_TIMEOUT_EN
                  r_idleCnt <= '0;
`endif
                  if (in_row == r_curRow) begin
                     r_buf <= w_bufPlaced;
                     if (in_last) begin
                        r_wea         <= 1'b1;
                        r_addra       <= r_curRow;
                        r_dina        <= w_bufPlaced;
                        r_rowsWritten <= r_rowsWritten + CNT_W'(1);
                        r_inReady     <= 1'b0;
                        r_state       <= S_FLUSH;
                     end
                  end else if (in_row > r_curRow) begin
                     // The finished row is written now; the new tuple waits one cycle in pending.
                     r_pendRow     <= in_row;
                     r_pendCol     <= in_col;
                     r_pendElem    <= in_elem;
                     r_pendLast    <= in_last;
                     r_wea         <= 1'b1;
                     r_addra       <= r_curRow;
                     r_dina        <= r_buf;
                     r_rowsWritten <= r_rowsWritten + CNT_W'(1);
                     r_inReady     <= 1'b0;
                     r_state       <= S_COMMIT;
                  end else begin
                     r_errOrder <= 1'b1;
                     if (in_last) begin
                        r_wea         <= 1'b1;
                        r_addra       <= r_curRow;
                        r_dina        <= r_buf;
                        r_rowsWritten <= r_rowsWritten + CNT_W'(1);
                        r_inReady     <= 1'b0;
                        r_state       <= S_FLUSH;
                     end
                  end
               end
`ifdef LOAD_TIMEOUT_EN
               else if (r_idleCnt == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                  r_wea         <= 1'b1;
                  r_addra       <= r_curRow;
                  r_dina        <= r_buf;
                  r_rowsWritten <= r_rowsWritten + CNT_W'(1);
                  r_inReady     <= 1'b0;
                  r_timeout     <= 1'b1;
                  r_state       <= S_FLUSH;
               end
`endif
            end

            S_COMMIT: begin
               r_buf    <= w_pendPlaced;
               r_curRow <= r_pendRow;
               if (r_pendLast) begin
                  r_wea         <= 1'b1;
                  r_addra       <= r_pendRow;
                  r_dina        <= w_pendPlaced;
                  r_rowsWritten <= r_rowsWritten + CNT_W'(1);
                  r_state       <= S_FLUSH;
               end else begin
                  r_inReady <= 1'b1;
                  r_state   <= S_FILL;
               end
            end

            S_FLUSH: begin
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end

            S_DONE: begin
               r_inReady <= 1'b1;
               r_busy    <= 1'b0;
               r_state   <= S_IDLE;
            end

            default: begin
               r_inReady <= 1'b1;
               r_busy    <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready     = r_inReady;
   assign bram_wea     = r_wea;
   assign bram_addra   = r_addra;
   assign bram_dina    = r_dina;
   assign matrix_done  = r_done;
   assign rows_written = r_rowsWritten;
   assign busy         = r_busy;
   assign err_order    = r_errOrder;

`ifdef LOAD_TIMEOUT_EN
   assign timeout = r_timeout;
`else
   // Without the watchdog, TIMEOUT_CYCLES has no effect and the pulse never fires.
   assign timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_matrix_load_sequencer.sv
// Directed self-checking bench for matrix_load_sequencer; the watchdog scenario
// runs only when LOAD_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_matrix_load_sequencer;

   localparam int ELEM_W   = 8;
   localparam int MAX_COLS = 32;
   localparam int MAX_ROWS = 32;
   localparam int TMO      = 16;
   localparam int DATA_W   = MAX_COLS * ELEM_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              inValid = 1'b0;
   logic              inLast = 1'b0;
   logic [4:0]        inRow = '0;
   logic [4:0]        inCol = '0;
   logic [7:0]        inElem = '0;
   logic              in_ready;
   logic [4:0]        bram_addra;
   logic [DATA_W-1:0] bram_dina;
   logic              bram_wea;
   logic              matrix_done;
   logic [5:0]        rows_written;
   logic              busy;
   logic              err_order;
   logic              timeout;

   matrix_load_sequencer #(
      .ELEM_W(ELEM_W), .MAX_COLS(MAX_COLS), .MAX_ROWS(MAX_ROWS), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .inter_refclk(clk), .rst(rst), .in_valid(inValid), .in_ready(in_ready),
      .in_row(inRow), .in_col(inCol), .in_elem(inElem), .in_last(inLast),
      .bram_addra(bram_addra), .bram_dina(bram_dina), .bram_wea(bram_wea),
      .matrix_done(matrix_done), .rows_written(rows_written), .busy(busy),
      .err_order(err_order), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int tests = 0;
   int fails = 0;
   int lastAcc = 0;

   logic [4:0]        wrAddr[$];
   logic [DATA_W-1:0] wrData[$];
   int                wrCyc[$];
   int                doneCyc[$];
   int                lowCyc[$];
   int                tmoCyc[$];

   // Cycle counter advances on each rising edge; the log samples on the falling edge.
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bram_wea) begin
         wrAddr.push_back(bram_addra);
         wrData.push_back(bram_dina);
         wrCyc.push_back(cyc);
      end
      if (matrix_done) doneCyc.push_back(cyc);
      if (!in_ready)   lowCyc.push_back(cyc);
      if (timeout)     tmoCyc.push_back(cyc);
   end

   task automatic clearLog();
      wrAddr.delete(); wrData.delete(); wrCyc.delete();
      doneCyc.delete(); lowCyc.delete(); tmoCyc.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Presents one tuple and holds it until an edge where in_ready was high.
   task automatic sendTuple(input logic [4:0] row, input logic [4:0] col,
                            input logic [7:0] elem, input logic last);
      logic rdy;
      int   guard;
      guard   = 0;
      inValid = 1'b1; inRow = row; inCol = col; inElem = elem; inLast = last;
      do begin
         rdy = in_ready;
         @(posedge clk); #1;
         guard++;
      end while (!rdy && guard < 20);
      if (!rdy) begin
         tests++; fails++;
         $display("[TB] FAIL accept_timeout: tuple row %0d col %0d not accepted in 20 cycles", row, col);
      end
      lastAcc = cyc;
      inValid = 1'b0; inLast = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(3);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
      tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      tests++; if (bram_wea !== 1'b0 || bram_addra !== 5'd0 || bram_dina !== '0) begin fails++; $display("[TB] FAIL reset_bram: wea %b addr %0d dina %h want all 0", bram_wea, bram_addra, bram_dina); end
      tests++; if (matrix_done !== 1'b0 || rows_written !== 6'd0 || err_order !== 1'b0 || timeout !== 1'b0) begin fails++; $display("[TB] FAIL reset_status: done %b rows %0d err %b tmo %b want all 0", matrix_done, rows_written, err_order, timeout); end
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_full_row();
      logic [DATA_W-1:0] exp;
      logic [DATA_W-1:0] got;
      clearLog();
      exp = '0;
      for (int c = 0; c < 32; c++) begin
         exp[(31 - c) * 8 +: 8] = 8'(c + 1);
         sendTuple(5'd2, 5'(c), 8'(c + 1), c == 31);
      end
      idle(4);
      tests++; if (wrAddr.size() != 1) begin fails++; $display("[TB] FAIL full_row_count: got %0d writes want 1", wrAddr.size()); end
      else begin
         got = wrData[0];
         tests++; if (wrAddr[0] !== 5'd2) begin fails++; $display("[TB] FAIL full_row_addr: got %0d want 2", wrAddr[0]); end
         tests++; if (got[255:248] !== 8'h01 || got[7:0] !== 8'h20) begin fails++; $display("[TB] FAIL full_row_ends: msb %h lsb %h want 01 20", got[255:248], got[7:0]); end
         tests++; if (got !== exp) begin fails++; $display("[TB] FAIL full_row_data: got %h want %h", got, exp); end
         tests++; if (wrCyc[0] != lastAcc) begin fails++; $display("[TB] FAIL full_row_wr_lat: got cycle %0d want %0d", wrCyc[0], lastAcc); end
      end
      tests++; if (doneCyc.size() != 1 || doneCyc[0] != lastAcc + 1) begin fails++; $display("[TB] FAIL full_row_done: got %0d pulses first %0d want 1 at %0d", doneCyc.size(), (doneCyc.size() > 0) ? doneCyc[0] : -1, lastAcc + 1); end
      tests++; if (rows_written !== 6'd1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL full_row_rows: rows %0d busy %b want 1 0", rows_written, busy); end
   endtask

   task automatic test_multi_row();
      logic [DATA_W-1:0] exp;
      int lows;
      clearLog();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 4; c++)
            sendTuple(5'(r), 5'(c), 8'(r * 16 + c + 1), (r == 2) && (c == 3));
      idle(4);
      tests++; if (wrAddr.size() != 3) begin fails++; $display("[TB] FAIL multi_count: got %0d writes want 3", wrAddr.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            exp = '0;
            for (int c = 0; c < 4; c++) exp[(31 - c) * 8 +: 8] = 8'(i * 16 + c + 1);
            tests++; if (wrAddr[i] !== 5'(i) || wrData[i] !== exp) begin fails++; $display("[TB] FAIL multi_write%0d: addr %0d data %h want %0d %h", i, wrAddr[i], wrData[i], i, exp); end
         end
         lows = 0;
         foreach (lowCyc[k]) if (lowCyc[k] < wrCyc[2]) lows++;
         tests++; if (lows != 2) begin fails++; $display("[TB] FAIL multi_ready_low: got %0d low cycles before flush want 2", lows); end
      end
      tests++; if (rows_written !== 6'd3) begin fails++; $display("[TB] FAIL multi_rows: got %0d want 3", rows_written); end
   endtask

   task automatic test_order_error();
      logic [DATA_W-1:0] exp;
      logic [DATA_W-1:0] w;
      int found;
      clearLog();
      sendTuple(5'd5, 5'd0, 8'h01, 1'b0);
      sendTuple(5'd5, 5'd1, 8'h02, 1'b0);
      sendTuple(5'd3, 5'd2, 8'hAA, 1'b0);
      sendTuple(5'd5, 5'd3, 8'h04, 1'b1);
      idle(4);
      exp = '0;
      exp[255:248] = 8'h01; exp[247:240] = 8'h02; exp[231:224] = 8'h04;
      tests++; if (err_order !== 1'b1) begin fails++; $display("[TB] FAIL order_err_set: got %b want 1", err_order); end
      tests++; if (wrAddr.size() != 1 || wrAddr[0] !== 5'd5 || wrData[0] !== exp) begin fails++; $display("[TB] FAIL order_write: got %0d writes, want one to row 5 with %h", wrAddr.size(), exp); end
      found = 0;
      foreach (wrData[i]) begin
         w = wrData[i];
         for (int b = 0; b < 32; b++) if (w[b * 8 +: 8] == 8'hAA) found++;
      end
      tests++; if (found != 0) begin fails++; $display("[TB] FAIL order_dropped: got %0d bytes of AA want 0", found); end
      sendTuple(5'd0, 5'd0, 8'h10, 1'b1);
      tests++; if (err_order !== 1'b0) begin fails++; $display("[TB] FAIL order_err_clear: got %b want 0", err_order); end
      idle(4);
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] exp0;
      logic [DATA_W-1:0] exp1;
      clearLog();
      exp0 = '0; exp0[(31 - 4) * 8 +: 8] = 8'h11;
      exp1 = '0; exp1[255:248] = 8'h22;
      sendTuple(5'd1, 5'd4, 8'h11, 1'b0);
      sendTuple(5'd4, 5'd0, 8'h22, 1'b1);
      idle(5);
      tests++; if (wrAddr.size() != 2) begin fails++; $display("[TB] FAIL b2b_count: got %0d writes want 2", wrAddr.size()); end
      else begin
         tests++; if (wrAddr[0] !== 5'd1 || wrData[0] !== exp0 || wrCyc[0] != lastAcc) begin fails++; $display("[TB] FAIL b2b_commit: addr %0d cyc %0d data %h want 1 %0d %h", wrAddr[0], wrCyc[0], wrData[0], lastAcc, exp0); end
         tests++; if (wrAddr[1] !== 5'd4 || wrData[1] !== exp1 || wrCyc[1] != lastAcc + 1) begin fails++; $display("[TB] FAIL b2b_flush: addr %0d cyc %0d data %h want 4 %0d %h", wrAddr[1], wrCyc[1], wrData[1], lastAcc + 1, exp1); end
      end
      tests++; if (doneCyc.size() != 1 || doneCyc[0] != lastAcc + 2) begin fails++; $display("[TB] FAIL b2b_done: got %0d pulses first %0d want 1 at %0d", doneCyc.size(), (doneCyc.size() > 0) ? doneCyc[0] : -1, lastAcc + 2); end
      tests++; if (rows_written !== 6'd2) begin fails++; $display("[TB] FAIL b2b_rows: got %0d want 2", rows_written); end
   endtask

   task automatic test_mid_reset();
      logic [DATA_W-1:0] exp;
      clearLog();
      sendTuple(5'd7, 5'd0, 8'h31, 1'b0);
      sendTuple(5'd7, 5'd1, 8'h32, 1'b0);
      sendTuple(5'd7, 5'd2, 8'h33, 1'b0);
      rst = 1'b1;
      idle(1);
      tests++; if (bram_wea !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || rows_written !== 6'd0) begin fails++; $display("[TB] FAIL midrst_outputs: wea %b rdy %b busy %b rows %0d want 0 1 0 0", bram_wea, in_ready, busy, rows_written); end
      rst = 1'b0;
      idle(1);
      tests++; if (wrAddr.size() != 0) begin fails++; $display("[TB] FAIL midrst_no_write: got %0d writes want 0", wrAddr.size()); end
      exp = '0; exp[(31 - 5) * 8 +: 8] = 8'h44;
      sendTuple(5'd7, 5'd5, 8'h44, 1'b1);
      idle(4);
      tests++; if (wrAddr.size() != 1 || wrAddr[0] !== 5'd7 || wrData[0] !== exp) begin fails++; $display("[TB] FAIL midrst_clean_buf: got %0d writes, want one to row 7 with %h", wrAddr.size(), exp); end
   endtask

   task automatic test_timeout();
      logic [DATA_W-1:0] exp;
      clearLog();
      sendTuple(5'd3, 5'd0, 8'h55, 1'b0);
`ifdef LOAD_TIMEOUT_EN
      idle(22);
      exp = '0; exp[255:248] = 8'h55;
      tests++; if (wrAddr.size() != 1 || wrAddr[0] !== 5'd3 || wrData[0] !== exp) begin fails++; $display("[TB] FAIL tmo_write: got %0d writes, want one to row 3 with %h", wrAddr.size(), exp); end
      else begin
         tests++; if (wrCyc[0] != lastAcc + TMO) begin fails++; $display("[TB] FAIL tmo_latency: got cycle %0d want %0d", wrCyc[0], lastAcc + TMO); end
      end
      tests++; if (tmoCyc.size() != 1 || tmoCyc[0] != lastAcc + TMO) begin fails++; $display("[TB] FAIL tmo_pulse: got %0d pulses first %0d want 1 at %0d", tmoCyc.size(), (tmoCyc.size() > 0) ? tmoCyc[0] : -1, lastAcc + TMO); end
      tests++; if (doneCyc.size() != 1 || doneCyc[0] != lastAcc + TMO + 1) begin fails++; $display("[TB] FAIL tmo_done: got %0d pulses first %0d want 1 at %0d", doneCyc.size(), (doneCyc.size() > 0) ? doneCyc[0] : -1, lastAcc + TMO + 1); end
`else
      idle(30);
      tests++; if (wrAddr.size() != 0 || tmoCyc.size() != 0 || busy !== 1'b1) begin fails++; $display("[TB] FAIL notmo_wait: writes %0d pulses %0d busy %b want 0 0 1", wrAddr.size(), tmoCyc.size(), busy); end
      sendTuple(5'd3, 5'd1, 8'h66, 1'b1);
      idle(4);
      exp = '0; exp[255:248] = 8'h55; exp[247:240] = 8'h66;
      tests++; if (wrAddr.size() != 1 || wrAddr[0] !== 5'd3 || wrData[0] !== exp) begin fails++; $display("[TB] FAIL notmo_write: got %0d writes, want one to row 3 with %h", wrAddr.size(), exp); end
`endif
   endtask

   initial begin
      #1;
      test_reset();
      test_full_row();
      test_multi_row();
      test_order_error();
      test_back_to_back();
      test_mid_reset();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
